// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and common constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int UART_DATA_BITS       = 8;
  localparam int UART_DEFAULT_CLK_DIV = 434;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte-load strobes from the transmit controller plus the serial line and status returned to it.
interface uart_tx_serializer_if;
  import uart_pkg::*;

  logic                      ld_tx_data;
  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      tx_enable;
  logic                      tx_out;
  logic                      tx_empty;
  logic                      busy;
  logic                      tx_overrun;

  modport master (
    output ld_tx_data, tx_data, tx_enable,
    input  tx_out, tx_empty, busy, tx_overrun
  );

  modport slave (
    input  ld_tx_data, tx_data, tx_enable,
    output tx_out, tx_empty, busy, tx_overrun
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: pulses tick on the last cycle of each CLK_DIV-cycle bit, restartable via clear.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_DIV = UART_DEFAULT_CLK_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [15:0] LAST_COUNT = 16'(CLK_DIV - 1);

  logic [15:0] count;

  assign tick = (count == LAST_COUNT);

  // Count through one bit period, wrapping on tick or restarting when the owner clears it.
  always_ff @(posedge clock) begin
    if (reset || clear || tick)
      count <= '0;
    else
      count <= count + 16'd1;
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1/8N2 UART transmitter with a one-byte holding register and sticky overrun flag.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = UART_DEFAULT_CLK_DIV,
  parameter int STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  uart_tx_serializer_if.slave  bus
);

  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_t               state;
  uart_state_t               state_next;
  logic [UART_DATA_BITS-1:0] hold;
  logic                      hold_full;
  logic                      overrun;
  logic [UART_DATA_BITS-1:0] shift;
  logic [UART_DATA_BITS-1:0] shift_next;
  logic [2:0]                bit_idx;
  logic [2:0]                bit_idx_next;
  logic                      stop_cnt;
  logic                      stop_cnt_next;
  logic                      tx_out_q;
  logic                      tx_out_next;
  logic                      busy_q;
  logic                      tick;
  logic                      baud_clear;
  logic                      last_stop;
  logic                      transfer;

  // A frame boundary is the final tick of the final stop bit; a new byte may launch from there or from idle.
  assign last_stop  = (state == STOP) && tick && (stop_cnt == STOP_LAST);
  assign transfer   = hold_full && bus.tx_enable && ((state == IDLE) || last_stop);
  // Restart the bit timer on every state entry so each state gets full bit periods.
  assign baud_clear = (state_next != state) || (state == IDLE);

  uart_baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_tick (
    .clock (clock),
    .reset (reset),
    .clear (baud_clear),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic: walk start, eight data bits and stop bits, chaining frames without a gap.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (transfer) state_next = START;
      START:   if (tick) state_next = DATA;
      DATA:    if (tick && (bit_idx == 3'd7)) state_next = STOP;
      STOP:    if (last_stop) state_next = transfer ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output/datapath logic: next shift contents, bit counters and the line level for the coming cycle.
  always_comb begin
    shift_next    = shift;
    bit_idx_next  = bit_idx;
    stop_cnt_next = stop_cnt;
    if (transfer) begin
      shift_next   = hold;
      bit_idx_next = '0;
    end else if ((state == DATA) && tick) begin
      shift_next   = shift >> 1;
      bit_idx_next = bit_idx + 3'd1;
    end
    if (last_stop || (state != STOP))
      stop_cnt_next = 1'b0;
    else if (tick)
      stop_cnt_next = stop_cnt + 1'b1;
    case (state_next)
      START:   tx_out_next = 1'b0;
      DATA:    tx_out_next = shift_next[0];
      default: tx_out_next = 1'b1;
    endcase
  end

  // Register the shifter, counters and line-side outputs so nothing reaches the pins combinationally.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift    <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      tx_out_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      shift    <= shift_next;
      bit_idx  <= bit_idx_next;
      stop_cnt <= stop_cnt_next;
      tx_out_q <= tx_out_next;
      busy_q   <= (state_next != IDLE);
    end
  end

  // Holding register: a load landing on a full register survives only if the old byte leaves that same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold      <= '0;
      hold_full <= 1'b0;
      overrun   <= 1'b0;
    end else if (bus.ld_tx_data) begin
      if (!hold_full || transfer) begin
        hold      <= bus.tx_data;
        hold_full <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (transfer) begin
      hold_full <= 1'b0;
    end
  end

  assign bus.tx_out     = tx_out_q;
  assign bus.busy       = busy_q;
  assign bus.tx_empty   = !hold_full;
  assign bus.tx_overrun = overrun;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: a per-cycle line-waveform model checks two serializer configurations every cycle.
module tb_uart_tx_serializer;

  logic clock;
  logic reset;
  logic check_en;
  int   total;
  int   bad;

  uart_tx_serializer_if bus0();
  uart_tx_serializer_if bus1();

  uart_tx_serializer #(.CLK_DIV(4), .STOP_BITS(1)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  uart_tx_serializer #(.CLK_DIV(3), .STOP_BITS(2)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  // Model state per instance: remaining frame waveform (one entry per clock), holding register, overrun.
  logic       wave [2][64];
  int         wlen [2];
  logic       mhold_full [2];
  logic [7:0] mhold [2];
  logic       movr [2];
  logic       exp_tx [2];
  logic       exp_busy [2];
  logic       exp_empty [2];
  logic       exp_ovr [2];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock: the line plays out the queued frame; a queued byte launches when the line is idle
  // or on the final cycle of the current frame.
  task automatic modelStep(input int k, input int div, input int stops, input logic rst,
                           input logic ld, input logic [7:0] d, input logic en);
    logic       xfer;
    logic [7:0] b;
    logic       lvl;
    if (rst) begin
      wlen[k]       = 0;
      mhold_full[k] = 1'b0;
      movr[k]       = 1'b0;
    end else begin
      xfer = mhold_full[k] && en && (wlen[k] <= 1);
      b    = mhold[k];
      if (wlen[k] > 0) begin
        for (int i = 0; i < wlen[k] - 1; i++) wave[k][i] = wave[k][i+1];
        wlen[k]--;
      end
      if (xfer) begin
        for (int j = 0; j < 9 + stops; j++) begin
          if (j == 0) lvl = 1'b0;
          else if (j <= 8) lvl = b[j-1];
          else lvl = 1'b1;
          for (int c = 0; c < div; c++) begin
            wave[k][wlen[k]] = lvl;
            wlen[k]++;
          end
        end
      end
      if (ld) begin
        if (!mhold_full[k] || xfer) begin
          mhold[k]      = d;
          mhold_full[k] = 1'b1;
        end else begin
          movr[k] = 1'b1;
        end
      end else if (xfer) begin
        mhold_full[k] = 1'b0;
      end
    end
    exp_tx[k]    = (wlen[k] > 0) ? wave[k][0] : 1'b1;
    exp_busy[k]  = (wlen[k] > 0);
    exp_empty[k] = !mhold_full[k];
    exp_ovr[k]   = movr[k];
  endtask

  // Step both models on every active edge using the inputs the DUTs sample.
  always @(posedge clock) begin
    modelStep(0, 4, 1, reset, bus0.ld_tx_data, bus0.tx_data, bus0.tx_enable);
    modelStep(1, 3, 2, reset, bus1.ld_tx_data, bus1.tx_data, bus1.tx_enable);
  end

  // Compare every DUT output with the model mid-cycle.
  always @(negedge clock) begin
    if (check_en) begin
      checkOutput("d0_tx_out",   64'(bus0.tx_out),     64'(exp_tx[0]));
      checkOutput("d0_busy",     64'(bus0.busy),       64'(exp_busy[0]));
      checkOutput("d0_tx_empty", 64'(bus0.tx_empty),   64'(exp_empty[0]));
      checkOutput("d0_overrun",  64'(bus0.tx_overrun), 64'(exp_ovr[0]));
      checkOutput("d1_tx_out",   64'(bus1.tx_out),     64'(exp_tx[1]));
      checkOutput("d1_busy",     64'(bus1.busy),       64'(exp_busy[1]));
      checkOutput("d1_tx_empty", 64'(bus1.tx_empty),   64'(exp_empty[1]));
      checkOutput("d1_overrun",  64'(bus1.tx_overrun), 64'(exp_ovr[1]));
    end
  end

  task automatic applyStimulus(input int k, input logic ld, input logic [7:0] d, input logic en);
    if (k == 0) begin
      bus0.ld_tx_data = ld;
      bus0.tx_data    = d;
      bus0.tx_enable  = en;
      bus1.ld_tx_data = 1'b0;
    end else begin
      bus1.ld_tx_data = ld;
      bus1.tx_data    = d;
      bus1.tx_enable  = en;
      bus0.ld_tx_data = 1'b0;
    end
    @(negedge clock);
  endtask

  task automatic idleCycles(input int k, input logic en, input int n);
    for (int i = 0; i < n; i++) applyStimulus(k, 1'b0, 8'h00, en);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(0, 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [39:0] rec;
    int          cnt;
    int          low;
    check_en        = 1'b0;
    total           = 0;
    bad             = 0;
    reset           = 1'b1;
    bus0.ld_tx_data = 1'b0; bus0.tx_data = 8'h00; bus0.tx_enable = 1'b0;
    bus1.ld_tx_data = 1'b0; bus1.tx_data = 8'h00; bus1.tx_enable = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("rst_tx_out",   64'(bus0.tx_out),     64'd1);
    checkOutput("rst_tx_empty", 64'(bus0.tx_empty),   64'd1);
    checkOutput("rst_busy",     64'(bus0.busy),       64'd0);
    checkOutput("rst_overrun",  64'(bus0.tx_overrun), 64'd0);
    check_en = 1'b1;
    reset    = 1'b0;
    idleCycles(0, 1'b1, 3);

    // Test 1: 0xA5 frame shape and busy width.
    applyStimulus(0, 1'b1, 8'hA5, 1'b1);
    checkOutput("t1_empty_after_load", 64'(bus0.tx_empty), 64'd0);
    applyStimulus(0, 1'b0, 8'h00, 1'b1);
    rec = '0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      rec = {rec[38:0], bus0.tx_out};
      cnt += int'(bus0.busy);
      applyStimulus(0, 1'b0, 8'h00, 1'b1);
    end
    checkOutput("t1_waveform", 64'(rec), 64'h0F0F00F0FF);
    checkOutput("t1_busy_cycles", 64'(cnt), 64'd40);
    checkOutput("t1_busy_after", 64'(bus0.busy), 64'd0);
    idleCycles(0, 1'b1, 3);

    // Test 2: back-to-back frames with no idle gap.
    applyStimulus(0, 1'b1, 8'h55, 1'b1);
    idleCycles(0, 1'b1, 10);
    applyStimulus(0, 1'b1, 8'h0F, 1'b1);
    idleCycles(0, 1'b1, 29);
    checkOutput("t2_last_stop_line",  64'(bus0.tx_out),   64'd1);
    checkOutput("t2_last_stop_empty", 64'(bus0.tx_empty), 64'd0);
    applyStimulus(0, 1'b0, 8'h00, 1'b1);
    checkOutput("t2_next_start_line",  64'(bus0.tx_out),   64'd0);
    checkOutput("t2_next_start_empty", 64'(bus0.tx_empty), 64'd1);
    checkOutput("t2_next_start_busy",  64'(bus0.busy),     64'd1);
    idleCycles(0, 1'b1, 45);

    // Test 3: third load while holding register is full is dropped.
    applyStimulus(0, 1'b1, 8'h11, 1'b1);
    idleCycles(0, 1'b1, 2);
    applyStimulus(0, 1'b1, 8'h22, 1'b1);
    idleCycles(0, 1'b1, 1);
    applyStimulus(0, 1'b1, 8'h33, 1'b1);
    checkOutput("t3_overrun_set", 64'(bus0.tx_overrun), 64'd1);
    cnt = 0;
    for (int i = 0; i < 90; i++) begin
      cnt += int'(bus0.busy);
      applyStimulus(0, 1'b0, 8'h00, 1'b1);
    end
    checkOutput("t3_busy_two_frames", 64'(cnt), 64'd76);
    checkOutput("t3_overrun_sticky", 64'(bus0.tx_overrun), 64'd1);
    doReset();
    checkOutput("t3_overrun_cleared", 64'(bus0.tx_overrun), 64'd0);

    // Test 4: enable gating and mid-frame enable drop.
    applyStimulus(0, 1'b1, 8'h80, 1'b0);
    idleCycles(0, 1'b0, 5);
    checkOutput("t4_gated_line",  64'(bus0.tx_out),   64'd1);
    checkOutput("t4_gated_empty", 64'(bus0.tx_empty), 64'd0);
    checkOutput("t4_gated_busy",  64'(bus0.busy),     64'd0);
    applyStimulus(0, 1'b0, 8'h00, 1'b1);
    checkOutput("t4_start_bit", 64'(bus0.tx_out), 64'd0);
    idleCycles(0, 1'b1, 12);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      cnt += int'(bus0.busy);
      applyStimulus(0, 1'b0, 8'h00, 1'b0);
    end
    checkOutput("t4_frame_completes", 64'(cnt), 64'd28);

    // Test 5: reset during data bit 3 of 0xFF.
    applyStimulus(0, 1'b1, 8'hFF, 1'b1);
    idleCycles(0, 1'b1, 18);
    checkOutput("t5_in_data_bit", 64'(bus0.tx_out), 64'd1);
    checkOutput("t5_in_data_busy", 64'(bus0.busy), 64'd1);
    reset = 1'b1;
    applyStimulus(0, 1'b0, 8'h00, 1'b1);
    reset = 1'b0;
    checkOutput("t5_rst_line",  64'(bus0.tx_out),   64'd1);
    checkOutput("t5_rst_empty", 64'(bus0.tx_empty), 64'd1);
    checkOutput("t5_rst_busy",  64'(bus0.busy),     64'd0);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      cnt += int'(bus0.busy);
      applyStimulus(0, 1'b0, 8'h00, 1'b1);
    end
    checkOutput("t5_no_frame", 64'(cnt), 64'd0);

    // Test 6: two stop bits, three clocks per bit, 0x00.
    applyStimulus(1, 1'b1, 8'h00, 1'b1);
    applyStimulus(1, 1'b0, 8'h00, 1'b1);
    cnt = 0;
    low = 0;
    for (int i = 0; i < 40; i++) begin
      cnt += int'(bus1.busy);
      low += int'(!bus1.tx_out);
      applyStimulus(1, 1'b0, 8'h00, 1'b1);
    end
    checkOutput("t6_low_cycles",  64'(low), 64'd27);
    checkOutput("t6_busy_cycles", 64'(cnt), 64'd33);

    idleCycles(0, 1'b1, 2);
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Byte-level UART transmitter. It sits directly downstream of the UART transmit controller and consumes that controller's `ld_tx_data` / `tx_data` / `tx_enable` strobes. Each accepted byte goes into a one-byte holding register. The byte is then serialised as 8N1 (or 8N2) onto the physical TX pin at a bit period set by a parameter. `tx_empty` and `busy` status flow back upstream for pacing.

## Interface
Parameters:
- `CLK_DIV`, default 434: clock cycles per bit (50 MHz / 115200). Legal range 2..65535.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.

Ports:
- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `ld_tx_data`  in  1  one-cycle load strobe; captures `tx_data` into the holding register
- `tx_data`  in  8  byte to send; sampled only when `ld_tx_data`=1
- `tx_enable`  in  1  permits the start of a new frame; has no effect on a frame already in progress
- `tx_out`  out  1  serial line, idle high, registered
- `tx_empty`  out  1  holding register empty (can accept a load)
- `busy`  out  1  a frame is in progress (state ≠ IDLE)
- `tx_overrun`  out  1  sticky flag: a load was dropped; cleared only by reset

## Operation
- Holding register `hold` plus flag `hold_full`. `tx_empty` = !`hold_full`.
- Load rules:
  - `ld_tx_data` with `hold_full`=0: load `hold`, set `hold_full`.
  - `ld_tx_data` with `hold_full`=1 and no transfer in the same cycle: drop the byte and set `tx_overrun`.
  - `ld_tx_data` in the same cycle as a hold→shift transfer: accept the load, keep `hold_full`=1, no overrun.
- Transfer: `hold` → 8-bit `shift`, clear `hold_full`, enter START. This happens when `hold_full` && `tx_enable` && (state=IDLE, or last cycle of the final stop bit).
- FSM states IDLE, START, DATA, STOP. Each bit lasts exactly `CLK_DIV` cycles, counted by the baud counter (0..`CLK_DIV`-1). The counter is cleared on every state entry.
  - IDLE: `tx_out`=1. Go to START on transfer.
  - START: `tx_out`=0. At counter end go to DATA, bit index = 0.
  - DATA: `tx_out`=`shift[0]` (LSB first). At counter end, shift right and increment the 3-bit index. After index 7 completes, go to STOP.
  - STOP: `tx_out`=1 for `STOP_BITS`×`CLK_DIV` cycles. At the end, transfer if the conditions hold (back-to-back frame, no idle gap); otherwise go to IDLE.
- Frame length is exactly (9+`STOP_BITS`)×`CLK_DIV` cycles.
- If `tx_enable` drops mid-frame, the frame completes. No new frame starts until `tx_enable`=1 with `hold_full`=1.

## Timing
- Reset values: `tx_out`=1, `tx_empty`=1, `busy`=0, `tx_overrun`=0; state IDLE; counters 0.
- `ld_tx_data` at cycle t (IDLE, empty, `tx_enable`=1):
  - `tx_empty`=0 at t+1.
  - Transfer at t+1, so `tx_empty`=1 again at t+2.
  - `tx_out`=0 and `busy`=1 from t+2.
- `tx_enable` rising while `hold_full`=1 in IDLE: start bit appears 1 cycle later.
- `busy` falls on the first IDLE cycle. It stays high across back-to-back frames.
- Reset mid-frame: next cycle `tx_out`=1, buffer discarded, all outputs at reset values.
- All outputs are registered; there are no combinational input→output paths.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, STOP)
  - `UART_DATA_BITS`=8
  - `UART_DEFAULT_CLK_DIV`=434
- Sub-module `uart_baud_tick`:
  - 16-bit counter with a synchronous clear input.
  - Emits a one-cycle `tick` on count `CLK_DIV`-1, then wraps to 0.
  - The top level clears it on every state entry.
- Top level contains the holding register, overrun logic, FSM and shift register.

## Test plan
(`CLK_DIV`=4 unless noted.)
1. Reset, then load 0xA5 with `tx_enable`=1 → expected response:
   - `tx_out` low 4 cycles starting t+2.
   - Then bits 1,0,1,0,0,1,0,1, 4 cycles each.
   - Then high 4 cycles.
   - `busy` high exactly 40 cycles.
2. Load 0x55, then load 0x0F while the first byte is shifting → 0x0F start bit immediately follows the 0x55 stop bit (no gap). `tx_empty` returns to 1 at that transfer.
3. Load 0x11, then 0x22 (holding register fills), then 0x33 before 0x22 is transferred → line carries only 0x11 and 0x22, and `tx_overrun`=1 until reset.
4. Load 0x80 with `tx_enable`=0 → `tx_out` stays 1 and `tx_empty`=0. Raise `tx_enable` → start bit 1 cycle later. Drop `tx_enable` at bit 2 → full frame still completes.
5. Assert `reset` during data bit 3 of 0xFF → next cycle `tx_out`=1, `tx_empty`=1, `busy`=0, and no further frame.
6. `STOP_BITS`=2, `CLK_DIV`=3, load 0x00 → line low 27 cycles, high 6 cycles; `busy` high 33 cycles.
